// File: rtl/tty_uart_ctl.sv
// tty_uart_ctl: PDP-8 console teletype controller sequencing an async UART (baud clocks, four-phase handshakes, TTI/TTO flags)
module tty_uart_ctl #(
  parameter int RX_DIV = 326
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tto_wr,
  input  logic [7:0] tto_data,
  input  logic       tto_flag_clr,
  output logic       tto_flag,
  input  logic       tti_rd,
  output logic [7:0] tti_data,
  output logic       tti_flag,
  input  logic       int_en,
  output logic       irq,
  output logic       tx_clk,
  output logic       rx_clk,
  output logic       uart_tx_req,
  input  logic       uart_tx_ack,
  output logic [7:0] uart_tx_data,
  input  logic       uart_tx_empty,
  output logic       uart_rx_req,
  input  logic       uart_rx_ack,
  input  logic [7:0] uart_rx_data,
  input  logic       uart_rx_empty
);
  localparam int DW = $clog2(RX_DIV);
  typedef enum logic [2:0] {TX_IDLE, TX_WAIT, TX_REQ, TX_REL, TX_DRAIN} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_REQ, RX_REL, RX_CAP} rx_state_t;
  tx_state_t tx_state;
  rx_state_t rx_state;
  logic [1:0] tx_ack_q, tx_empty_q, rx_ack_q, rx_empty_q;
  logic [DW-1:0] div_cnt;
  logic [3:0] baud_cnt;
  logic tx_ack_s, tx_empty_s, rx_ack_s, rx_empty_s, div_half, div_last, seen_busy;
  assign tx_ack_s = tx_ack_q[1];
  assign tx_empty_s = tx_empty_q[1];
  assign rx_ack_s = rx_ack_q[1];
  assign rx_empty_s = rx_empty_q[1];
  assign div_half = div_cnt == DW'(RX_DIV / 2 - 1);
  assign div_last = div_cnt == DW'(RX_DIV - 1);
  assign tx_clk = baud_cnt[3];
  assign irq = int_en & (tto_flag | tti_flag);
  // empty synchronisers reset high so no unload is requested before real status arrives
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_ack_q <= 2'b00;
      rx_ack_q <= 2'b00;
      tx_empty_q <= 2'b11;
      rx_empty_q <= 2'b11;
      div_cnt <= '0;
      rx_clk <= 1'b0;
      baud_cnt <= 4'd0;
    end else begin
      tx_ack_q <= {tx_ack_q[0], uart_tx_ack};
      rx_ack_q <= {rx_ack_q[0], uart_rx_ack};
      tx_empty_q <= {tx_empty_q[0], uart_tx_empty};
      rx_empty_q <= {rx_empty_q[0], uart_rx_empty};
      div_cnt <= div_last ? '0 : div_cnt + 1'b1;
      if (div_half || div_last) rx_clk <= ~rx_clk;
      if ((div_half || div_last) && !rx_clk) baud_cnt <= baud_cnt + 4'd1;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      uart_tx_req <= 1'b0;
      uart_tx_data <= 8'd0;
      tto_flag <= 1'b0;
      seen_busy <= 1'b0;
    end else begin
      if (tto_flag_clr) tto_flag <= 1'b0;
      if (tx_state inside {TX_REQ, TX_REL, TX_DRAIN} && !tx_empty_s) seen_busy <= 1'b1;
      case (tx_state)
        TX_IDLE: if (tto_wr) begin
          uart_tx_data <= tto_data;
          tto_flag <= 1'b0;
          tx_state <= TX_WAIT;
        end
        TX_WAIT: if (tx_empty_s) begin
          seen_busy <= 1'b0;
          uart_tx_req <= 1'b1;
          tx_state <= TX_REQ;
        end
        TX_REQ: if (tx_ack_s) begin
          uart_tx_req <= 1'b0;
          tx_state <= TX_REL;
        end
        TX_REL: if (!tx_ack_s) tx_state <= TX_DRAIN;
        TX_DRAIN: if (seen_busy && tx_empty_s) begin
          tto_flag <= 1'b1;
          tx_state <= TX_IDLE;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      uart_rx_req <= 1'b0;
      tti_data <= 8'd0;
      tti_flag <= 1'b0;
    end else begin
      if (tti_rd) tti_flag <= 1'b0;
      case (rx_state)
        RX_IDLE: if (!rx_empty_s && !tti_flag) begin
          uart_rx_req <= 1'b1;
          rx_state <= RX_REQ;
        end
        RX_REQ: if (rx_ack_s) begin
          uart_rx_req <= 1'b0;
          rx_state <= RX_REL;
        end
        RX_REL: if (!rx_ack_s && rx_empty_s) rx_state <= RX_CAP;
        RX_CAP: begin
          tti_data <= uart_rx_data;
          tti_flag <= 1'b1;
          rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end
endmodule
